// File: rtl/instruction_encoder.sv
// RV32I/Zicsr instruction encoder: accepts an operation index plus fields,
// builds the 32-bit word and streams it out one byte per handshake.
module instruction_encoder #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_last,
  output logic [31:0] out_word,
  output logic        error,
  output logic [15:0] instr_count
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  state_t      state_reg, state_next;
  logic [1:0]  idx_reg, idx_next;
  logic [31:0] word_reg, word_next;
  logic        error_reg, error_next;
  logic [15:0] count_reg, count_next;

  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] enc_word;
  logic        op_ok;
  logic        needs_align;
  logic [7:0]  lane [4];

  always_comb begin
    funct3 = 3'b000;
    case (in_op)
      6'd5, 6'd11, 6'd16, 6'd24, 6'd29, 6'd38, 6'd41:        funct3 = 3'b001;
      6'd12, 6'd17, 6'd19, 6'd30, 6'd42:                      funct3 = 3'b010;
      6'd20, 6'd31, 6'd43:                                    funct3 = 3'b011;
      6'd6, 6'd13, 6'd21, 6'd32:                              funct3 = 3'b100;
      6'd7, 6'd14, 6'd25, 6'd26, 6'd33, 6'd34, 6'd44:         funct3 = 3'b101;
      6'd8, 6'd22, 6'd35, 6'd45:                              funct3 = 3'b110;
      6'd9, 6'd23, 6'd36, 6'd46:                              funct3 = 3'b111;
      default:                                                funct3 = 3'b000;
    endcase
    funct7 = (in_op inside {6'd26, 6'd28, 6'd34}) ? 7'b0100000 : 7'b0000000;
  end

  always_comb begin
    enc_word    = 32'h0;
    op_ok       = 1'b1;
    needs_align = 1'b0;
    if (in_op == 6'd0)
      enc_word = {in_imm[31:12], in_rd, OPC_LUI};
    else if (in_op == 6'd1)
      enc_word = {in_imm[31:12], in_rd, OPC_AUIPC};
    else if (in_op == 6'd2) begin
      enc_word    = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
      needs_align = 1'b1;
    end else if (in_op == 6'd3)
      enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_JALR};
    else if (in_op inside {[6'd4:6'd9]}) begin
      enc_word    = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, funct3,
                     in_imm[4:1], in_imm[11], OPC_BRANCH};
      needs_align = 1'b1;
    end else if (in_op inside {[6'd10:6'd14]})
      enc_word = {in_imm[11:0], in_rs1, funct3, in_rd, OPC_LOAD};
    else if (in_op inside {[6'd15:6'd17]})
      enc_word = {in_imm[11:5], in_rs2, in_rs1, funct3, in_imm[4:0], OPC_STORE};
    else if (in_op inside {[6'd18:6'd23]})
      enc_word = {in_imm[11:0], in_rs1, funct3, in_rd, OPC_OPIMM};
    else if (in_op inside {[6'd24:6'd26]})
      enc_word = {funct7, in_imm[4:0], in_rs1, funct3, in_rd, OPC_OPIMM};
    else if (in_op inside {[6'd27:6'd36]})
      enc_word = {funct7, in_rs2, in_rs1, funct3, in_rd, OPC_OP};
    else if (in_op == 6'd37)
      enc_word = {4'b0000, in_imm[7:0], 5'd0, 3'b000, 5'd0, OPC_FENCE};
    else if (in_op == 6'd38)
      enc_word = {12'd0, 5'd0, 3'b001, 5'd0, OPC_FENCE};
    else if (in_op == 6'd39)
      enc_word = 32'h0000_0073;
    else if (in_op == 6'd40)
      enc_word = 32'h0010_0073;
    else if (in_op inside {[6'd41:6'd46]})
      // Immediate CSR forms carry uimm in the rs1 slot.
      enc_word = {in_imm[11:0], in_rs1, funct3, in_rd, OPC_SYSTEM};
    else if (in_op == 6'd47)
      enc_word = 32'h0000_0013;
    else
      op_ok = 1'b0;
  end

  // Lane gi is the byte presented when the index equals gi.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam int SRC = BIG_ENDIAN ? (3 - gi) : gi;
      assign lane[gi] = word_reg[8*SRC +: 8];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    word_next  = word_reg;
    error_next = 1'b0;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (!op_ok || (needs_align && in_imm[0])) begin
            error_next = 1'b1;
          end else begin
            word_next  = enc_word;
            idx_next   = 2'd0;
            state_next = SEND;
          end
        end
      end
      SEND: begin
        if (out_ready) begin
          idx_next = idx_reg + 2'd1;
          if (idx_reg == 2'd3) begin
            state_next = IDLE;
            count_next = count_reg + 16'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= 2'd0;
      word_reg  <= 32'h0;
      error_reg <= 1'b0;
      count_reg <= 16'h0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      word_reg  <= word_next;
      error_reg <= error_next;
      count_reg <= count_next;
    end
  end

  assign in_ready    = (state_reg == IDLE) && !reset;
  assign out_valid   = (state_reg == SEND);
  assign out_byte    = (state_reg == SEND) ? lane[idx_reg] : 8'h00;
  assign out_last    = (state_reg == SEND) && (idx_reg == 2'd3);
  assign out_word    = word_reg;
  assign error       = error_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: little- and big-endian instances share
// stimulus; expected bytes are queued at accept and popped as bytes are taken.
module tb_instruction_encoder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [5:0]  in_op = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, out_last, error;
  logic [7:0]  out_byte;
  logic [31:0] out_word;
  logic [15:0] instr_count;

  logic        be_in_ready, be_out_valid, be_out_last, be_error;
  logic [7:0]  be_out_byte;
  logic [31:0] be_out_word;
  logic [15:0] be_instr_count;

  typedef struct {
    logic [7:0]  le;
    logic [7:0]  be;
    logic        last;
    logic [31:0] word;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  instruction_encoder #(.BIG_ENDIAN(1'b0)) dut_le (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .out_last(out_last), .out_word(out_word), .error(error), .instr_count(instr_count)
  );

  instruction_encoder #(.BIG_ENDIAN(1'b1)) dut_be (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(be_in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(be_out_valid), .out_ready(out_ready), .out_byte(be_out_byte),
    .out_last(be_out_last), .out_word(be_out_word), .error(be_error),
    .instr_count(be_instr_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one request at a negedge; on a valid op queue its four expected bytes.
  task automatic issue(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm,
                       input logic [31:0] expw, input bit push);
    exp_t e;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    if (push) begin
      for (int b = 0; b < 4; b++) begin
        e.le   = expw[8*b +: 8];
        e.be   = expw[8*(3-b) +: 8];
        e.last = (b == 3);
        e.word = expw;
        sb.push_back(e);
      end
    end
  endtask

  // Take nbytes from the scoreboard; stall out_ready for 3 cycles on byte stall_idx.
  task automatic drain(input int nbytes, input int stall_idx);
    exp_t e;
    for (int b = 0; b < nbytes; b++) begin
      int t = 0;
      while (!out_valid && t < 10) begin
        @(negedge clock);
        t++;
      end
      chk("out_valid_wait", {31'd0, out_valid}, 32'd1);
      e = sb.pop_front();
      chk("out_byte", {24'd0, out_byte}, {24'd0, e.le});
      chk("be_out_byte", {24'd0, be_out_byte}, {24'd0, e.be});
      chk("out_last", {31'd0, out_last}, {31'd0, e.last});
      chk("out_word", out_word, e.word);
      $display("byte %0d: le=%h be=%h last=%0b word=%h", b, out_byte, be_out_byte, out_last, out_word);
      if (b == stall_idx) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clock);
          chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
          chk("stall_out_byte", {24'd0, out_byte}, {24'd0, e.le});
          chk("stall_out_last", {31'd0, out_last}, {31'd0, e.last});
          chk("stall_out_word", out_word, e.word);
        end
        out_ready = 1'b1;
      end
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic run(input string name, input logic [5:0] op, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                     input logic [31:0] expw, input int stall_idx, input logic [15:0] exp_cnt);
    issue(op, rd, rs1, rs2, imm, expw, 1'b1);
    chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
    drain(4, stall_idx);
    chk("out_valid_done", {31'd0, out_valid}, 32'd0);
    chk("instr_count", {16'd0, instr_count}, {16'd0, exp_cnt});
    chk("in_ready_done", {31'd0, in_ready}, 32'd1);
    $display("%s: word=%h count=%0d", name, out_word, instr_count);
  endtask

  task automatic bad(input string name, input logic [5:0] op, input logic [31:0] imm,
                     input logic [15:0] exp_cnt);
    issue(op, 5'd1, 5'd1, 5'd2, imm, 32'h0, 1'b0);
    chk("error_pulse", {31'd0, error}, 32'd1);
    chk("error_no_valid", {31'd0, out_valid}, 32'd0);
    chk("error_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clock);
    chk("error_clear", {31'd0, error}, 32'd0);
    chk("error_no_valid2", {31'd0, out_valid}, 32'd0);
    chk("error_count", {16'd0, instr_count}, {16'd0, exp_cnt});
    $display("%s: error pulse seen, count=%0d", name, instr_count);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_byte", {24'd0, out_byte}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_out_word", out_word, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_count", {16'd0, instr_count}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    run("addi",  6'd18, 5'd1, 5'd0, 5'd0, 32'd5,         32'h0050_0093, -1, 16'd1);
    run("beq",   6'd4,  5'd0, 5'd1, 5'd2, 32'd8,         32'h0020_8463, -1, 16'd2);
    run("sub",   6'd28, 5'd3, 5'd1, 5'd2, 32'd0,         32'h4020_81B3, -1, 16'd3);
    run("lui",   6'd0,  5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, -1, 16'd4);
    run("jal",   6'd2,  5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h0010_00EF, -1, 16'd5);
    run("csrrs", 6'd42, 5'd5, 5'd0, 5'd0, 32'h0000_0C00, 32'hC000_22F3, -1, 16'd6);
    run("srai",  6'd26, 5'd1, 5'd1, 5'd7, 32'hFFFF_FFE3, 32'h4030_D093, -1, 16'd7);
    run("ecall", 6'd39, 5'd9, 5'd9, 5'd9, 32'hFFFF_FFFF, 32'h0000_0073, -1, 16'd8);
    run("addi_stall", 6'd18, 5'd1, 5'd0, 5'd0, 32'd5,    32'h0050_0093, 1, 16'd9);

    bad("invalid_op", 6'd50, 32'd0, 16'd9);
    bad("beq_misaligned", 6'd4, 32'd3, 16'd9);
    chk("word_kept_after_error", out_word, 32'h0050_0093);

    issue(6'd18, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b1);
    drain(1, -1);
    reset = 1'b1;
    sb.delete();
    @(posedge clock);
    @(negedge clock);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_count", {16'd0, instr_count}, 32'd0);
    chk("abort_in_ready_in_reset", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("abort_in_ready_after", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid_after", {31'd0, out_valid}, 32'd0);
    chk("abort_count_after", {16'd0, instr_count}, 32'd0);
    $display("reset_abort: out_valid=%0b count=%0d in_ready=%0b", out_valid, instr_count, in_ready);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 The block SHALL have parameter BIG_ENDIAN, default 0, which selects byte order: 0 sends word[7:0] first, 1 sends word[31:24] first.
REQ-002 The block SHALL have port clock, input, 1 bit: the only clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: an instruction request is present.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the encoder can accept a request.
REQ-006 The block SHALL have port in_op, input, 6 bits: operation index per REQ-013.
REQ-007 The block SHALL have ports in_rd, in_rs1, in_rs2, inputs, 5 bits each: register fields (in_rs1 doubles as uimm for csrr*i).
REQ-008 The block SHALL have port in_imm, input, 32 bits: immediate, CSR address in bits [11:0], or shamt in bits [4:0].
REQ-009 The block SHALL have ports out_valid, output, 1 bit, and out_ready, input, 1 bit: byte-stream handshake.
REQ-010 The block SHALL have port out_byte, output, 8 bits: current instruction byte.
REQ-011 The block SHALL have ports out_last, output, 1 bit (final byte of the word), out_word, output, 32 bits (full encoded word, stable while sending), and error, output, 1 bit (one-cycle pulse).
REQ-012 The block SHALL have port instr_count, output, 16 bits: number of fully sent instructions.

Function
REQ-013 in_op indices SHALL map as follows:
- 0 lui; 1 auipc; 2 jal; 3 jalr
- 4-9 beq, bne, blt, bge, bltu, bgeu
- 10-14 lb, lh, lw, lbu, lhu
- 15-17 sb, sh, sw
- 18-23 addi, slti, sltiu, xori, ori, andi
- 24-26 slli, srli, srai
- 27-36 add, sub, sll, slt, sltu, xor, srl, sra, or, and
- 37 fence; 38 fence.i; 39 ecall; 40 ebreak
- 41-46 csrrw, csrrs, csrrc, csrrwi, csrrsi, csrrci
- 47 nop, encoded 0x00000013
- 48-63 invalid
REQ-014 Opcode, funct3 and funct7 SHALL be the RV32I/Zicsr values; sub, sra and srai SHALL use funct7 0100000, all other R-type and shift ops 0000000.
REQ-015 Immediate placement SHALL be:
- I-type: imm[11:0] to word[31:20]
- S-type: imm[11:5] to [31:25], imm[4:0] to [11:7]
- B-type: imm[12|10:5] to [31:25], imm[4:1|11] to [11:7]
- U-type: imm[31:12] to [31:12]
- J-type: imm[20|10:1|11|19:12] to [31:12]
- Shifts: imm[4:0] to [24:20]
- fence: imm[7:0] to [27:20] and [31:28]=0
- CSR: imm[11:0] to [31:20]
- Unused immediate bits are ignored.
REQ-016 ecall and ebreak SHALL encode as fixed 0x00000073 and 0x00100073, ignoring all field inputs; fields unused by a format SHALL be zero.
REQ-017 FSM states: IDLE and SEND, with a 2-bit byte index.
REQ-018 in_ready SHALL be 1 exactly when the FSM is in IDLE and reset is low.
REQ-019 Accept (in_valid and in_ready at an edge) with a valid op: out_word is registered, the index is set to 0, the FSM goes to SEND, and out_valid = 1 from the next cycle.
REQ-020 Accept with an invalid op, or with a B/J op where imm[0]=1: error = 1 for the next cycle only, the FSM stays in IDLE, out_word is unchanged and no bytes are sent.
REQ-021 In SEND, out_byte SHALL be the byte at the index in the order set by BIG_ENDIAN; out_last = 1 when the index is 3.
REQ-022 out_valid and out_ready at an edge: the index SHALL increment; on the last byte the FSM goes to IDLE, out_valid drops the next cycle and instr_count increments (wrapping 0xFFFF to 0x0000).
REQ-023 While out_ready is low, out_byte, out_last and out_word SHALL hold; out_valid SHALL NOT drop until the byte is taken.
REQ-024 Minimum period SHALL be 5 cycles per instruction: 1 accept cycle plus 4 byte cycles, with no overlap.

Reset
REQ-025 While reset is high at an edge, the block SHALL set: FSM IDLE, index 0, out_valid 0, out_byte 0, out_last 0, out_word 0, error 0, instr_count 0; in_ready SHALL be 0 during reset.
REQ-026 Reset mid-SEND SHALL abort the word: no further bytes are sent and instr_count is not incremented.

Verification
REQ-027 addi, rd=1, rs1=0, imm=5 -> out_word 0x00500093; bytes 93,00,50,00; out_last on the 4th byte; instr_count 1.
REQ-028 beq, rs1=1, rs2=2, imm=8 -> 0x00208463; sub, rd=3, rs1=1, rs2=2 -> 0x402081B3; lui, rd=5, imm=0x12345000 -> 0x123452B7.
REQ-029 BIG_ENDIAN=1 with the addi of REQ-027 -> bytes 00,50,00,93.
REQ-030 out_ready held low for 3 cycles while byte 1 is presented -> out_byte stays 0x00 and out_valid stays high; the remaining bytes follow unchanged.
REQ-031 in_op=50, then beq with imm=3 -> error pulses one cycle each, no out_valid, instr_count unchanged.
REQ-032 Reset asserted after byte 1 is sent -> out_valid 0 next cycle, instr_count 0, in_ready 1 on the first cycle after reset is released.
